// File: rtl/acc_pkg.sv
// Shared defaults, width helper and result record for windowed_accumulator.
// Optional saturation is selected with the ACC_SAT_EN macro (see acc_lane).
package acc_pkg;

  // Tag width for n items: clog2 with a floor of one bit so a single channel still has a port.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IN_W     = 32;
  localparam int DEF_ACC_W    = 40;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WINDOW   = 8;
  localparam int DEF_CH_W     = ch_w(DEF_CHANNELS);

  typedef struct packed {
    logic [DEF_CH_W-1:0]  ch;
    logic [DEF_ACC_W-1:0] sum;
    logic                 ovf;
  } acc_result_t;

endpackage

// File: rtl/acc_lane.sv
// One channel of the windowed accumulator: running sum, sample count and sticky overflow.
// ACC_SAT_EN defined: clamp to all-ones on carry; undefined: wrap modulo 2^ACC_W.
module acc_lane
  import acc_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             i_hit,
  input  logic [IN_W-1:0]  i_data,
  output logic             o_done,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  localparam int CNT_W = ch_w(WINDOW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic [ACC_W:0]   w_nxt;
  logic             w_carry;
  logic [ACC_W-1:0] w_sum;
  logic             w_last;

  assign w_nxt   = {1'b0, r_acc} + (ACC_W + 1)'(i_data);
  assign w_carry = w_nxt[ACC_W];
  assign w_last  = (r_cnt == LAST);

`ifdef ACC_SAT_EN
  // Once clamped the accumulator stays all-ones: any further non-zero add carries again.
  assign w_sum = w_carry ? {ACC_W{1'b1}} : w_nxt[ACC_W-1:0];
`else
  assign w_sum = w_nxt[ACC_W-1:0];
`endif

  assign o_done = i_hit && w_last;
  assign o_sum  = w_sum;
  assign o_ovf  = r_ovf | w_carry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_hit) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
        r_ovf <= r_ovf | w_carry;
      end
    end
  end

endmodule

// File: rtl/windowed_accumulator.sv
// Multi-channel windowed accumulator: tagged samples in, one result per channel per WINDOW samples.
// Build option ACC_SAT_EN selects saturating sums inside acc_lane.
module windowed_accumulator
  import acc_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WINDOW   = DEF_WINDOW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ch_w(CHANNELS)-1:0]   in_ch,
  input  logic [IN_W-1:0]             in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ch_w(CHANNELS)-1:0]   out_ch,
  output logic [ACC_W-1:0]            out_sum,
  output logic                        out_ovf
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid, once
  // raised, holds with stable payload until taken. Input readiness follows the single
  // output register, so the input stalls only while a result waits unconsumed.

  localparam int CH_W = ch_w(CHANNELS);
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CHANNELS);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [ACC_W-1:0] sum;
    logic             ovf;
  } res_t;

  res_t                r_res;
  logic                r_out_valid;

  logic                w_accept;
  logic                w_ch_ok;
  logic [CHANNELS-1:0] w_lane_hit;
  logic [CHANNELS-1:0] w_lane_done;
  logic [CHANNELS-1:0] w_lane_ovf;
  logic [ACC_W-1:0]    w_lane_sum [CHANNELS];
  logic [ACC_W-1:0]    w_sel_sum;
  logic                w_sel_ovf;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !clr;
  assign w_ch_ok  = ({1'b0, in_ch} < CH_LIM);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign w_lane_hit[c] = w_accept && w_ch_ok && (in_ch == CH_W'(c));

    acc_lane #(
      .IN_W   (IN_W),
      .ACC_W  (ACC_W),
      .WINDOW (WINDOW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .i_hit  (w_lane_hit[c]),
      .i_data (in_data),
      .o_done (w_lane_done[c]),
      .o_sum  (w_lane_sum[c]),
      .o_ovf  (w_lane_ovf[c])
    );
  end

  // At most one lane is hit per cycle, so a priority-free select is enough.
  always_comb begin
    w_sel_sum = '0;
    w_sel_ovf = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_lane_done[c]) begin
        w_sel_sum = w_lane_sum[c];
        w_sel_ovf = w_lane_ovf[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
    end else if (clr) begin
      r_out_valid <= 1'b0;
    end else if (|w_lane_done) begin
      r_out_valid <= 1'b1;
      r_res.ch    <= in_ch;
      r_res.sum   <= w_sel_sum;
      r_res.ovf   <= w_sel_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_res.ch;
  assign out_sum   = r_res.sum;
  assign out_ovf   = r_res.ovf;

endmodule
